// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: tracks the EX and MEM stage destinations
// and picks operand sources, flag forwarding and stall for the RF-stage instruction.
module fwd_hazard_unit #(
  parameter int unsigned REGW = 5,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_Rn,
  input  logic [REGW-1:0] id_Db,
  input  logic            id_useA,
  input  logic            id_useB,
  input  logic [REGW-1:0] id_Rd,
  input  logic            id_RegWrite,
  input  logic            id_MemRead,
  input  logic            id_flagSet,
  input  logic            id_flagUse,
  input  logic            flush,
  output logic [1:0]      forwardOpA,
  output logic [1:0]      forwardOpB,
  output logic            forwarding_flags,
  output logic            stall,
  output logic [CNTW-1:0] stall_count
);

  localparam logic [REGW-1:0] XZR = REGW'(31);

  typedef struct packed {
    logic            valid;
    logic [REGW-1:0] rd;
    logic            reg_write;
    logic            mem_read;
    logic            flag_set;
  } entry_t;

  entry_t          ex_q, ex_d;
  entry_t          mem_q, mem_d;
  logic [CNTW-1:0] stall_count_q, stall_count_d;

  logic ex_writer, mem_writer;
  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;

  always_comb begin
    ex_writer  = ex_q.valid && ex_q.reg_write && (ex_q.rd != XZR);
    mem_writer = mem_q.valid && mem_q.reg_write && (mem_q.rd != XZR);

    ex_hit_a  = id_useA && ex_writer && (ex_q.rd == id_Rn);
    ex_hit_b  = id_useB && ex_writer && (ex_q.rd == id_Db);
    mem_hit_a = id_useA && mem_writer && (mem_q.rd == id_Rn);
    mem_hit_b = id_useB && mem_writer && (mem_q.rd == id_Db);

    // A load in EX has no result yet: it cannot be forwarded, only stalled on
    forwardOpA = 2'b00;
    if (ex_hit_a && !ex_q.mem_read) forwardOpA = 2'b01;
    else if (mem_hit_a)             forwardOpA = 2'b10;

    forwardOpB = 2'b00;
    if (ex_hit_b && !ex_q.mem_read) forwardOpB = 2'b01;
    else if (mem_hit_b)             forwardOpB = 2'b10;

    stall            = id_valid && ex_q.mem_read && (ex_hit_a || ex_hit_b);
    forwarding_flags = id_valid && id_flagUse && ex_q.valid && ex_q.flag_set;

    mem_d           = ex_q;
    ex_d.valid      = id_valid && !stall && !flush;
    ex_d.rd         = id_Rd;
    ex_d.reg_write  = id_RegWrite;
    ex_d.mem_read   = id_MemRead;
    ex_d.flag_set   = id_flagSet;

    stall_count_d = stall_count_q;
    if (stall && !flush && (stall_count_q != '1))
      stall_count_d = stall_count_q + CNTW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q          <= '0;
      mem_q         <= '0;
      stall_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios plus randomized
// traffic checked against an instruction-history model.
module tb_fwd_hazard_unit;

  logic        clk;
  logic        reset;
  logic        id_valid, id_useA, id_useB, id_RegWrite, id_MemRead;
  logic        id_flagSet, id_flagUse, flush;
  logic [4:0]  id_Rn, id_Db, id_Rd;
  logic [1:0]  fwd_a, fwd_b, fwd_a2, fwd_b2;
  logic        ff, ff2, st, st2;
  logic [15:0] sc;
  logic [1:0]  sc2;

  int n_checks = 0;
  int n_fail   = 0;

  fwd_hazard_unit #(.REGW(5), .CNTW(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_Rn(id_Rn), .id_Db(id_Db),
    .id_useA(id_useA), .id_useB(id_useB), .id_Rd(id_Rd), .id_RegWrite(id_RegWrite),
    .id_MemRead(id_MemRead), .id_flagSet(id_flagSet), .id_flagUse(id_flagUse),
    .flush(flush), .forwardOpA(fwd_a), .forwardOpB(fwd_b),
    .forwarding_flags(ff), .stall(st), .stall_count(sc)
  );

  fwd_hazard_unit #(.REGW(5), .CNTW(2)) dut_small (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_Rn(id_Rn), .id_Db(id_Db),
    .id_useA(id_useA), .id_useB(id_useB), .id_Rd(id_Rd), .id_RegWrite(id_RegWrite),
    .id_MemRead(id_MemRead), .id_flagSet(id_flagSet), .id_flagUse(id_flagUse),
    .flush(flush), .forwardOpA(fwd_a2), .forwardOpB(fwd_b2),
    .forwarding_flags(ff2), .stall(st2), .stall_count(sc2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish (actual running, required finished)");
    $fatal(1);
  end

  task automatic drive(input logic v, input logic [4:0] rn, input logic [4:0] db,
                       input logic ua, input logic ub, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic fs,
                       input logic fu, input logic fl);
    id_valid = v;  id_Rn = rn;  id_Db = db;  id_useA = ua;  id_useB = ub;
    id_Rd = rd;  id_RegWrite = rw;  id_MemRead = mr;  id_flagSet = fs;
    id_flagUse = fu;  flush = fl;
    #2;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    // a would-be hazard on the inputs must not leak through cleared entries
    drive(1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0);
    n_checks += 6;
    if (fwd_a !== 2'b00) begin n_fail++; $display("FAIL reset_fwdA actual=%b required=00", fwd_a); end
    if (fwd_b !== 2'b00) begin n_fail++; $display("FAIL reset_fwdB actual=%b required=00", fwd_b); end
    if (ff !== 1'b0)     begin n_fail++; $display("FAIL reset_flags actual=%b required=0", ff); end
    if (st !== 1'b0)     begin n_fail++; $display("FAIL reset_stall actual=%b required=0", st); end
    if (sc !== 16'd0)    begin n_fail++; $display("FAIL reset_count actual=%0d required=0", sc); end
    if (sc2 !== 2'd0)    begin n_fail++; $display("FAIL reset_count_small actual=%0d required=0", sc2); end
    tick;
    reset = 1'b1;
  endtask

  task automatic test_alu_forward;
    do_reset;
    drive(1, 2, 3, 1, 1, 1, 1, 0, 0, 0, 0);       // ADD X1,X2,X3
    tick;
    drive(1, 1, 3, 1, 1, 2, 1, 0, 0, 0, 0);       // SUB X2,X1,X3
    n_checks += 3;
    if (fwd_a !== 2'b01) begin n_fail++; $display("FAIL alu_ex_fwdA actual=%b required=01", fwd_a); end
    if (fwd_b !== 2'b00) begin n_fail++; $display("FAIL alu_ex_fwdB actual=%b required=00", fwd_b); end
    if (st !== 1'b0)     begin n_fail++; $display("FAIL alu_ex_stall actual=%b required=0", st); end
    tick;
    drive(1, 1, 4, 1, 1, 8, 1, 0, 0, 0, 0);
    n_checks += 1;
    if (fwd_a !== 2'b10) begin n_fail++; $display("FAIL alu_mem_fwdA actual=%b required=10", fwd_a); end
  endtask

  task automatic test_load_use;
    do_reset;
    drive(1, 9, 0, 1, 0, 5, 1, 1, 0, 0, 0);       // LDUR X5,[X9]
    tick;
    drive(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0);       // ADD X6,X5,X5
    n_checks += 2;
    if (st !== 1'b1)  begin n_fail++; $display("FAIL lu_stall actual=%b required=1", st); end
    if (sc !== 16'd0) begin n_fail++; $display("FAIL lu_count_before actual=%0d required=0", sc); end
    tick;
    n_checks += 4;
    if (st !== 1'b0)     begin n_fail++; $display("FAIL lu_stall_after actual=%b required=0", st); end
    if (sc !== 16'd1)    begin n_fail++; $display("FAIL lu_count_after actual=%0d required=1", sc); end
    if (fwd_a !== 2'b10) begin n_fail++; $display("FAIL lu_fwdA actual=%b required=10", fwd_a); end
    if (fwd_b !== 2'b10) begin n_fail++; $display("FAIL lu_fwdB actual=%b required=10", fwd_b); end
  endtask

  task automatic test_priority_x31;
    do_reset;
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
    tick;
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
    tick;
    drive(1, 0, 7, 0, 1, 8, 1, 0, 0, 0, 0);
    n_checks += 2;
    if (fwd_b !== 2'b01) begin n_fail++; $display("FAIL prio_fwdB actual=%b required=01", fwd_b); end
    if (fwd_a !== 2'b00) begin n_fail++; $display("FAIL prio_unused_fwdA actual=%b required=00", fwd_a); end
    do_reset;
    drive(1, 0, 0, 0, 0, 31, 1, 0, 0, 0, 0);
    tick;
    drive(1, 0, 0, 0, 0, 31, 1, 1, 0, 0, 0);
    tick;
    drive(1, 31, 31, 1, 1, 8, 1, 0, 0, 0, 0);
    n_checks += 3;
    if (fwd_b !== 2'b00) begin n_fail++; $display("FAIL x31_fwdB actual=%b required=00", fwd_b); end
    if (fwd_a !== 2'b00) begin n_fail++; $display("FAIL x31_fwdA actual=%b required=00", fwd_a); end
    if (st !== 1'b0)     begin n_fail++; $display("FAIL x31_stall actual=%b required=0", st); end
  endtask

  task automatic test_flags;
    do_reset;
    drive(1, 2, 3, 1, 1, 1, 1, 0, 1, 0, 0);       // ADDS
    tick;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);       // B.LT
    n_checks += 1;
    if (ff !== 1'b1) begin n_fail++; $display("FAIL flags_fwd actual=%b required=1", ff); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    n_checks += 1;
    if (ff !== 1'b0) begin n_fail++; $display("FAIL flags_bubble actual=%b required=0", ff); end
    do_reset;
    drive(1, 2, 3, 1, 1, 1, 1, 0, 1, 0, 0);
    tick;
    drive(1, 2, 3, 1, 1, 4, 1, 0, 0, 0, 0);       // ADD, no flags
    tick;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    n_checks += 1;
    if (ff !== 1'b0) begin n_fail++; $display("FAIL flags_intervening actual=%b required=0", ff); end
  endtask

  task automatic test_flush_stall;
    do_reset;
    drive(1, 9, 0, 1, 0, 5, 1, 1, 0, 0, 0);
    tick;
    drive(1, 5, 0, 1, 0, 6, 1, 0, 0, 0, 1);
    n_checks += 1;
    if (st !== 1'b1) begin n_fail++; $display("FAIL flush_stall_comb actual=%b required=1", st); end
    tick;
    drive(1, 6, 0, 1, 0, 7, 1, 0, 0, 0, 0);       // reads X6: only the flushed op would write it
    n_checks += 3;
    if (sc !== 16'd0)    begin n_fail++; $display("FAIL flush_count actual=%0d required=0", sc); end
    if (fwd_a !== 2'b00) begin n_fail++; $display("FAIL flush_bubble_fwdA actual=%b required=00", fwd_a); end
    if (st !== 1'b0)     begin n_fail++; $display("FAIL flush_bubble_stall actual=%b required=0", st); end
  endtask

  task automatic test_saturate;
    do_reset;
    for (int i = 0; i < 5; i++) begin
      drive(1, 9, 0, 1, 0, 5, 1, 1, 0, 0, 0);
      tick;
      drive(1, 0, 5, 0, 1, 6, 1, 0, 0, 0, 0);
      tick;
      tick;
    end
    n_checks += 2;
    if (sc !== 16'd5) begin n_fail++; $display("FAIL sat_count_wide actual=%0d required=5", sc); end
    if (sc2 !== 2'd3) begin n_fail++; $display("FAIL sat_count_small actual=%0d required=3", sc2); end
  endtask

  task automatic test_reset_midstream;
    do_reset;
    drive(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0);
    tick;
    drive(1, 0, 0, 0, 0, 2, 1, 1, 1, 0, 0);
    tick;
    drive(1, 1, 2, 1, 1, 3, 1, 0, 0, 1, 0);
    n_checks += 3;
    if (fwd_a !== 2'b10) begin n_fail++; $display("FAIL mid_pre_fwdA actual=%b required=10", fwd_a); end
    if (st !== 1'b1)     begin n_fail++; $display("FAIL mid_pre_stall actual=%b required=1", st); end
    if (ff !== 1'b1)     begin n_fail++; $display("FAIL mid_pre_flags actual=%b required=1", ff); end
    reset = 1'b0;
    #1;
    n_checks += 4;
    if (fwd_a !== 2'b00) begin n_fail++; $display("FAIL mid_rst_fwdA actual=%b required=00", fwd_a); end
    if (fwd_b !== 2'b00) begin n_fail++; $display("FAIL mid_rst_fwdB actual=%b required=00", fwd_b); end
    if (st !== 1'b0)     begin n_fail++; $display("FAIL mid_rst_stall actual=%b required=0", st); end
    if (ff !== 1'b0)     begin n_fail++; $display("FAIL mid_rst_flags actual=%b required=0", ff); end
    tick;
    reset = 1'b1;
    #1;
    n_checks += 2;
    if (fwd_a !== 2'b00) begin n_fail++; $display("FAIL mid_rel_fwdA actual=%b required=00", fwd_a); end
    if (fwd_b !== 2'b00) begin n_fail++; $display("FAIL mid_rel_fwdB actual=%b required=00", fwd_b); end
  endtask

  // Model: the two most recently issued instructions, youngest first.
  typedef struct {
    bit       real_op;
    bit [4:0] dst;
    bit       writes;
    bit       is_load;
    bit       sets_flags;
  } issued_t;

  function automatic bit produces(issued_t op, bit [4:0] r);
    return op.real_op && op.writes && (op.dst != 5'd31) && (op.dst == r);
  endfunction

  function automatic int src_sel(issued_t older0, issued_t older1, bit use_it, bit [4:0] r);
    if (!use_it)                                  return 0;
    if (produces(older0, r) && !older0.is_load)   return 1;
    if (produces(older1, r))                      return 2;
    return 0;
  endfunction

  task automatic test_random;
    issued_t hist [2];
    issued_t cur;
    int      cnt, e_a, e_b;
    bit      e_st, e_ff;
    bit [4:0] regs [5];
    regs[0] = 0; regs[1] = 1; regs[2] = 2; regs[3] = 3; regs[4] = 31;
    do_reset;
    hist[0] = '{0, 0, 0, 0, 0};
    hist[1] = '{0, 0, 0, 0, 0};
    cnt = 0;
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 9) < 8), regs[$urandom_range(0, 4)], regs[$urandom_range(0, 4)],
            1'($urandom), 1'($urandom), regs[$urandom_range(0, 4)], ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0));
      e_a  = src_sel(hist[0], hist[1], id_useA, id_Rn);
      e_b  = src_sel(hist[0], hist[1], id_useB, id_Db);
      e_st = id_valid && hist[0].is_load &&
             ((id_useA && produces(hist[0], id_Rn)) || (id_useB && produces(hist[0], id_Db)));
      e_ff = id_valid && id_flagUse && hist[0].real_op && hist[0].sets_flags;
      n_checks += 6;
      if (fwd_a !== 2'(e_a)) begin n_fail++; $display("FAIL rnd_fwdA cyc=%0d actual=%b required=%0d", i, fwd_a, e_a); end
      if (fwd_b !== 2'(e_b)) begin n_fail++; $display("FAIL rnd_fwdB cyc=%0d actual=%b required=%0d", i, fwd_b, e_b); end
      if (st !== e_st)       begin n_fail++; $display("FAIL rnd_stall cyc=%0d actual=%b required=%b", i, st, e_st); end
      if (ff !== e_ff)       begin n_fail++; $display("FAIL rnd_flags cyc=%0d actual=%b required=%b", i, ff, e_ff); end
      if (sc !== 16'(cnt))   begin n_fail++; $display("FAIL rnd_count cyc=%0d actual=%0d required=%0d", i, sc, cnt); end
      if (sc2 !== 2'((cnt > 3) ? 3 : cnt))
        begin n_fail++; $display("FAIL rnd_count_small cyc=%0d actual=%0d required=%0d", i, sc2, (cnt > 3) ? 3 : cnt); end
      cur.real_op    = id_valid && !e_st && !flush;
      cur.dst        = id_Rd;
      cur.writes     = id_RegWrite;
      cur.is_load    = id_MemRead;
      cur.sets_flags = id_flagSet;
      if (e_st && !flush) cnt++;
      hist[1] = hist[0];
      hist[0] = cur;
      tick;
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    test_reset;
    test_alu_forward;
    test_load_use;
    test_priority_x31;
    test_flags;
    test_flush_stall;
    test_saturate;
    test_reset_midstream;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL provide parameter REGW, default 5, register-index width.
REQ-002 SHALL provide parameter CNTW, default 16, stall-counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port id_valid, input, 1, the RF-stage instruction is real (not a bubble).
REQ-006 SHALL have ports id_Rn and id_Db, input, REGW each, RF-stage source registers A and B.
REQ-007 SHALL have ports id_useA and id_useB, input, 1 each, the RF-stage instruction reads A and B respectively.
REQ-008 SHALL have ports id_Rd, input, REGW; id_RegWrite, id_MemRead, id_flagSet and id_flagUse, input, 1 each; all are RF-stage control.
REQ-009 SHALL have port flush, input, 1, a taken branch; it squashes the RF-stage instruction.
REQ-010 SHALL have ports forwardOpA and forwardOpB, output, 2 each: 00 register file, 01 ALUOut, 10 DataMem.
REQ-011 SHALL have port forwarding_flags, output, 1, select the live EX-stage ALU flags.
REQ-012 SHALL have port stall, output, 1, hold PC and the IF/RF register this cycle.
REQ-013 SHALL have port stall_count, output, CNTW, the saturating count of load-use stall cycles.

Function
REQ-014 SHALL hold two tracking entries, EX and MEM; each entry holds {valid, rd, RegWrite, MemRead, flagSet}.
REQ-015 SHALL treat an entry as a writer only when valid=1, RegWrite=1 and rd!=31; X31 is never forwarded.
REQ-016 SHALL, for source A, output 01 when id_useA=1 and EX is a writer with EX.MemRead=0 and EX.rd=id_Rn.
REQ-017 SHALL otherwise output 10 for source A when id_useA=1 and MEM is a writer with MEM.rd=id_Rn; otherwise 00.
REQ-018 SHALL apply REQ-016/017 identically to source B using id_useB and id_Db; EX has priority over MEM.
REQ-019 SHALL assert stall combinationally when id_valid=1, EX is a writer, EX.MemRead=1, and (id_useA with EX.rd=id_Rn, or id_useB with EX.rd=id_Db).
REQ-020 SHALL assert forwarding_flags when id_valid=1, id_flagUse=1, EX.valid=1 and EX.flagSet=1; otherwise 0.
REQ-021 SHALL, each rising edge, load MEM from EX.
REQ-022 SHALL, on the same edge, load EX from the RF-stage fields; EX.valid=id_valid and not stall and not flush.
REQ-023 SHALL clear EX.valid on flush regardless of stall; stall is still reported combinationally that cycle.
REQ-024 SHALL increment stall_count by 1 each edge where stall=1 and flush=0, saturating at 2^CNTW-1 without wrap.
REQ-025 SHALL keep all outputs except stall_count combinational from current entries and inputs; forwarding decisions have zero-cycle latency.
REQ-026 SHALL resolve a load-use stall in exactly one cycle: after the bubble, the load sits in MEM and the consumer gets 10.

Reset
REQ-027 SHALL, while reset=0, asynchronously clear EX and MEM entries (all fields 0) and stall_count to 0.
REQ-028 SHALL drive forwardOpA=forwardOpB=00, forwarding_flags=0 and stall=0 out of reset until a valid writer enters.
REQ-029 SHALL discard in-flight entries on reset mid-operation; on release, tracking restarts empty.

Verification
REQ-030 ADD X1,... then SUB X2,X1,X3 next cycle -> forwardOpA=01, stall=0; one cycle later with X1 source -> forwardOpA=10.
REQ-031 LDUR X5 then ADD X6,X5,X5 -> stall=1 for one cycle, stall_count 0->1; next cycle forwardOpA=forwardOpB=10, stall=0.
REQ-032 EX and MEM both write X7, consumer reads X7 on B -> forwardOpB=01; writer with rd=31 -> forwardOpB=00.
REQ-033 ADDS in EX, B.LT in RF -> forwarding_flags=1; an intervening non-flag-setting instruction -> forwarding_flags=0.
REQ-034 Load-use hazard coincident with flush=1 -> EX becomes bubble, stall_count unchanged; CNTW=2 with 5 stalls -> stall_count holds 3.
REQ-035 reset pulled low mid-stream with EX and MEM valid -> all outputs 0 immediately; first cycle after release -> forwardOp 00.
